// File: rtl/seq_shift_pkg.sv
// Shared types and constants for the iterative right barrel shifter.
package seq_shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_t;

    localparam logic MODE_ROTATE  = 1'b0;
    localparam logic MODE_LOGICAL = 1'b1;

endpackage

// File: rtl/right_shift_stage.sv
// One log2 stage of the right shifter: moves data right by 2**i_stage when enabled.
module right_shift_stage
    import seq_shift_pkg::*;
#(
    parameter int width = 3
) (
    input  logic [2**width-1:0] i_data,
    input  logic [width-1:0]    i_stage,
    input  logic                i_enable,
    input  logic                i_mode,
    output logic [2**width-1:0] o_data
);

    localparam int N = 2**width;

    logic [width:0] w_amt;
    logic [N-1:0]   w_rot;
    logic [N-1:0]   w_log;

    assign w_amt = (width+1)'(1) << i_stage;

    // Rotation falls out of shifting a doubled copy and keeping the low half.
    assign w_rot = N'({i_data, i_data} >> w_amt);
    assign w_log = i_data >> w_amt;

    assign o_data = !i_enable                ? i_data :
                    (i_mode == MODE_LOGICAL) ? w_log  : w_rot;

endmodule

// File: rtl/seq_right_shifter.sv
// Iterative handshaked right barrel shifter, one log2 stage resolved per clock.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for a request
//   SHIFT | applying stage r_stage of the latched shift amount
//   DONE  | result on output_string, out_valid high until out_ready
module seq_right_shifter
    import seq_shift_pkg::*;
#(
    parameter int width = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2**width-1:0] input_string,
    input  logic [width-1:0]    shift,
    input  logic                mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2**width-1:0] output_string,
    output logic                busy
);

    localparam int N = 2**width;
    localparam logic [width-1:0] STAGE_LAST = (width)'(width - 1);

    shift_state_t     r_state;
    logic [N-1:0]     r_data;
    logic [width-1:0] r_shift;
    logic             r_mode;
    logic [width-1:0] r_stage;

    shift_state_t     w_state_nxt;
    logic [N-1:0]     w_data_nxt;
    logic [width-1:0] w_shift_nxt;
    logic             w_mode_nxt;
    logic [width-1:0] w_stage_nxt;
    logic             w_en;
    logic [N-1:0]     w_stage_data;

    always_comb begin
        w_en = 1'b0;
        for (int i = 0; i < width; i++) begin
            if (int'(r_stage) == i) begin
                w_en = r_shift[i];
            end
        end
    end

    right_shift_stage #(.width(width)) u_stage (
        .i_data   (r_data),
        .i_stage  (r_stage),
        .i_enable (w_en),
        .i_mode   (r_mode),
        .o_data   (w_stage_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_shift_nxt = r_shift;
        w_mode_nxt  = r_mode;
        w_stage_nxt = r_stage;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_data_nxt  = input_string;
                    w_shift_nxt = shift;
                    w_mode_nxt  = mode;
                    w_stage_nxt = '0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // Every stage runs even when its bit is clear, keeping latency fixed.
                w_data_nxt  = w_stage_data;
                w_stage_nxt = r_stage + 1'b1;
                if (r_stage == STAGE_LAST) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_shift <= '0;
            r_mode  <= 1'b0;
            r_stage <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_shift <= w_shift_nxt;
            r_mode  <= w_mode_nxt;
            r_stage <= w_stage_nxt;
        end
    end

    assign in_ready      = (r_state == IDLE);
    assign out_valid     = (r_state == DONE);
    assign busy          = (r_state == SHIFT) || (r_state == DONE);
    assign output_string = r_data;

endmodule
